// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
package regfile_pkg;
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_NREGS = 32;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/Decoder_5to32.sv
// Binary-to-one-hot register decoder; purely combinational.
module Decoder_5to32
  import regfile_pkg::*;
#(
  parameter int AW = RF_AW
) (
  input  logic [AW-1:0]      i_addr,
  output logic [2**AW-1:0]   o_onehot
);
  always_comb begin
    o_onehot         = '0;
    o_onehot[i_addr] = 1'b1;
  end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with bus locking for the single register-file write port; one-cycle write stage, x0 writes dropped.
// Optional per-requester saturating grant counters are built when REGFILE_WR_ARB_STATS_EN is defined.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [N_REQ-1:0]    i_req,
  input  logic [N_REQ-1:0]    i_lock,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [2**AW-1:0]    o_rf_we,
  output logic [AW-1:0]       o_rf_waddr,
  output logic [DW-1:0]       o_rf_wdata,
  output logic                o_busy
`ifdef REGFILE_WR_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0] o_stat_gnt_cnt
`endif
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state, w_state_nxt;
  logic [IW-1:0]    r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]    r_owner, w_owner_nxt;
  logic [IW-1:0]    w_cand, w_gnt_idx;
  logic             w_found, w_gnt_vld;
  logic [N_REQ-1:0] w_gnt;
  logic [AW-1:0]    w_sel_addr;
  logic [DW-1:0]    w_sel_wdata;
  logic             w_sel_lock;
  logic             r_wr_vld;
  logic [AW-1:0]    r_waddr;
  logic [DW-1:0]    r_wdata;
  logic [2**AW-1:0] w_dec;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
    if (int'(idx) == N_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  // Winner search: rotate from rr_ptr while idle, only the owner while locked.
  always_comb begin
    w_gnt     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_cand    = '0;
    if (r_state == ARB_IDLE) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_cand = IW'((int'(r_rr_ptr) + k) % N_REQ);
        if (!w_found && i_req[w_cand]) begin
          w_found   = 1'b1;
          w_gnt_idx = w_cand;
        end
      end
    end else if (i_req[r_owner]) begin
      w_found   = 1'b1;
      w_gnt_idx = r_owner;
    end
    w_gnt_vld = w_found & i_rst_n;
    if (w_gnt_vld) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_lock  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(w_gnt_idx) == i) begin
        w_sel_addr  = i_addr[i*AW +: AW];
        w_sel_wdata = i_wdata[i*DW +: DW];
        w_sel_lock  = i_lock[i];
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_owner_nxt  = r_owner;
    case (r_state)
      ARB_IDLE: begin
        if (w_found) begin
          w_rr_ptr_nxt = wrap_inc(w_gnt_idx);
          if (w_sel_lock) begin
            w_state_nxt = ARB_LOCKED;
            w_owner_nxt = w_gnt_idx;
          end
        end
      end
      ARB_LOCKED: begin
        if (!i_lock[r_owner]) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = wrap_inc(r_owner);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ARB_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wr_vld <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_owner  <= w_owner_nxt;
      r_wr_vld <= w_found;
      if (w_found) begin
        r_waddr <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

  Decoder_5to32 #(.AW(AW)) u_dec (
    .i_addr   (r_waddr),
    .o_onehot (w_dec)
  );

  // r_wr_vld clears asynchronously, so reset kills a pending write at once.
  assign o_rf_we    = (r_wr_vld && (r_waddr != '0)) ? w_dec : '0;
  assign o_rf_waddr = r_waddr;
  assign o_rf_wdata = r_wdata;
  assign o_busy     = (r_state == ARB_LOCKED);
  assign o_gnt      = w_gnt;

`ifdef REGFILE_WR_ARB_STATS_EN
  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    logic [15:0] r_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)                          r_cnt <= '0;
      else if (w_gnt[g] && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
    end
    assign o_stat_gnt_cnt[g*16 +: 16] = r_cnt;
  end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus contract-respecting random traffic against an arbitration model.
module tb_regfile_wr_arbiter;
  localparam int N  = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req, lock;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [31:0]     rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            busy;
`ifdef REGFILE_WR_ARB_STATS_EN
  logic [N*16-1:0] stat;
`endif

  regfile_wr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .i_lock     (lock),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .o_gnt      (gnt),
    .o_rf_we    (rf_we),
    .o_rf_waddr (rf_waddr),
    .o_rf_wdata (rf_wdata),
    .o_busy     (busy)
`ifdef REGFILE_WR_ARB_STATS_EN
    ,
    .o_stat_gnt_cnt (stat)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          m_rr, m_owner;
  bit          m_locked;
  logic [31:0] m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_cnt[N];

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_owner = 0; m_locked = 0;
    m_we = '0; m_waddr = '0; m_wdata = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  function automatic int model_gnt();
    if (!rst_n) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int k = 0; k < N; k++)
      if (req[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Called at posedge+1 with inputs driven; checks, advances the model, returns at next posedge+1.
  task automatic cycle(input bit do_chk, output int g);
    logic [N-1:0]    eg;
    logic [AW-1:0]   a;
`ifdef REGFILE_WR_ARB_STATS_EN
    logic [N*16-1:0] ms;
`endif
    #1;
    g  = model_gnt();
    eg = '0;
    if (g >= 0) eg = {{(N-1){1'b0}}, 1'b1} << g;
    if (do_chk) begin
      check_eq("gnt", 64'(gnt), 64'(eg));
      check_eq("rf_we", 64'(rf_we), 64'(m_we));
      check_eq("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
      check_eq("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      check_eq("busy", 64'(busy), 64'(m_locked));
`ifdef REGFILE_WR_ARB_STATS_EN
      for (int i = 0; i < N; i++) ms[i*16 +: 16] = 16'(m_cnt[i]);
      check_eq("stat_cnt", 64'(stat), 64'(ms));
`endif
    end
    if (g >= 0) begin
      a       = addr[g*AW +: AW];
      m_we    = (a != 0) ? (32'd1 << a) : 32'd0;
      m_waddr = a;
      m_wdata = wdata[g*DW +: DW];
      if (m_cnt[g] < 65535) m_cnt[g]++;
    end else begin
      m_we = '0;
    end
    if (!m_locked) begin
      if (g >= 0) begin
        m_rr = (g + 1) % N;
        if (lock[g]) begin
          m_locked = 1;
          m_owner  = g;
        end
      end
    end else if (!lock[m_owner]) begin
      m_locked = 0;
      m_rr     = (m_owner + 1) % N;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           g;
    logic [N-1:0] pend;

    model_reset();
    rst_n = 1'b0; req = 2'b11; lock = '0; addr = '0; wdata = '0;
    #12;
    check_eq("rst_gnt", 64'(gnt), 64'd0);
    check_eq("rst_rf_we", 64'(rf_we), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_waddr", 64'(rf_waddr), 64'd0);
    @(negedge clk); rst_n = 1'b1; req = '0;
    @(posedge clk); #1;

    // Round-robin alternation
    req = 2'b11; set_req(0, 5'd3, 32'hA); set_req(1, 5'd7, 32'hB);
    #1 check_eq("rr_gnt0", 64'(gnt), 64'h1);
    cycle(1, g);
    check_eq("rr_we0", 64'(rf_we), 64'h8);
    check_eq("rr_wd0", 64'(rf_wdata), 64'hA);
    #1 check_eq("rr_gnt1", 64'(gnt), 64'h2);
    cycle(1, g);
    check_eq("rr_we1", 64'(rf_we), 64'h80);
    check_eq("rr_wd1", 64'(rf_wdata), 64'hB);
    #1 check_eq("rr_gnt2", 64'(gnt), 64'h1);
    cycle(1, g);
    check_eq("rr_we2", 64'(rf_we), 64'h8);

    // x0 write is granted but dropped
    req = 2'b01; set_req(0, 5'd0, 32'hFFFF_FFFF);
    #1 check_eq("x0_gnt", 64'(gnt), 64'h1);
    cycle(1, g);
    check_eq("x0_we", 64'(rf_we), 64'h0);

    // Lock burst by requester 1, requester 0 stalled
    req = 2'b11; lock = 2'b10; set_req(0, 5'd5, 32'h55);
    for (int j = 1; j <= 4; j++) begin
      set_req(1, 5'(j), 32'(j * 16));
      #1 check_eq("lk_gnt", 64'(gnt), 64'h2);
      cycle(1, g);
      check_eq("lk_we", 64'(rf_we), 64'(32'd1 << j));
      check_eq("lk_busy", 64'(busy), 64'h1);
    end
    lock = 2'b00; set_req(1, 5'd6, 32'h66);
    #1 check_eq("unlk_gnt", 64'(gnt), 64'h2);
    cycle(1, g);
    check_eq("unlk_busy", 64'(busy), 64'h0);
    #1 check_eq("post_lk_gnt", 64'(gnt), 64'h1);
    cycle(1, g);

    // Asynchronous reset during a lock burst
    req = 2'b10; lock = 2'b10; set_req(1, 5'd9, 32'h99);
    cycle(1, g);
    cycle(1, g);
    check_eq("pre_rst_we", 64'(rf_we), 64'(32'd1 << 9));
    check_eq("pre_rst_busy", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_we", 64'(rf_we), 64'h0);
    check_eq("arst_busy", 64'(busy), 64'h0);
    check_eq("arst_gnt", 64'(gnt), 64'h0);
    model_reset();
    @(negedge clk); rst_n = 1'b1; req = '0; lock = '0;
    @(posedge clk); #1;
    req = 2'b11;
    #1 check_eq("arst_rr0", 64'(gnt), 64'h1);
    check_eq("arst_idle", 64'(busy), 64'h0);
    cycle(1, g);

    // Random traffic honoring the hold-until-grant contract
    pend = '0; req = '0; lock = '0;
    cycle(1, g);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_req(i, 5'($urandom_range(0, 31)), $urandom());
        end
        req[i]  = pend[i];
        lock[i] = ($urandom_range(0, 2) == 0);
      end
      cycle(1, g);
      if (g >= 0) pend[g] = 1'b0;
    end

`ifdef REGFILE_WR_ARB_STATS_EN
    #2 rst_n = 1'b0; req = '0; lock = '0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    req = 2'b01; set_req(0, 5'd1, 32'h1);
    for (int c = 0; c < 70000; c++) cycle(0, g);
    cycle(1, g);
    check_eq("stat_sat0", 64'(stat[15:0]), 64'hFFFF);
    check_eq("stat_zero1", 64'(stat[31:16]), 64'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between N requesters: core writeback, the UART debug loader, and any future requester. Selects one request per cycle by round-robin and supports bus locking for burst loads. Drives a registered one-hot write-enable vector, address and data into the register file. Writes to x0 are dropped at the arbiter so the register file never sees them.

Parameters:
N_REQ, 2, number of requesters (2..8); index 0 = core writeback
AW, 5, register address width; the one-hot width is 2**AW
DW, 32, data width

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
REQ  in  N_REQ  per-requester write request
LOCK  in  N_REQ  per-requester lock-hold; only meaningful while granted
ADDR  in  N_REQ*AW  packed write addresses; requester i at [i*AW +: AW]
WDATA  in  N_REQ*DW  packed write data; requester i at [i*DW +: DW]
GNT  out  N_REQ  one-hot, combinational; request accepted this cycle
RF_WE  out  2**AW  registered one-hot write enable, bit k = write register k
RF_WADDR  out  AW  registered write address
RF_WDATA  out  DW  registered write data
BUSY  out  1  registered; high while in LOCKED state

Behaviour:
- Clock and reset: one clock CLK. RST_N is asynchronous assert, synchronous deassert at the system level. All state is cleared on RST_N low.
- Reset values: RF_WE=0, RF_WADDR=0, RF_WDATA=0, BUSY=0, rr_ptr=0, state=IDLE, lock_owner=0. GNT is combinational and is 0 while RST_N is low.
- Grant rule in IDLE:
  - Search REQ starting at rr_ptr, wrapping modulo N_REQ. The first set bit wins.
  - Exactly one GNT bit is set when any REQ is set; GNT is 0 otherwise.
- Round-robin pointer: on any grant to i in IDLE, rr_ptr <= (i+1) mod N_REQ at the next edge. With no grant, rr_ptr holds.
- Lock: granted i with LOCK[i]=1 moves state to LOCKED and sets lock_owner=i.
- LOCKED state:
  - Only lock_owner can be granted; GNT[lock_owner] = REQ[lock_owner]. All other requesters are stalled.
  - A cycle with LOCK[lock_owner]=0 returns to IDLE at the next edge, whether or not REQ is set. A write in that same cycle is still granted.
  - rr_ptr is not advanced while LOCKED. On exit, rr_ptr <= (lock_owner+1) mod N_REQ.
- Write stage (latency 1): in the cycle after a grant, RF_WE = one-hot decode of the granted ADDR, and RF_WADDR/RF_WDATA hold the granted values. With no grant, RF_WE=0 and RF_WADDR/RF_WDATA hold their last values.
- x0 handling: granted ADDR==0 still asserts GNT (the requester completes), but RF_WE stays 0 the next cycle.
- Simultaneous requests: all REQ set with rr_ptr=k gives grants in order k, k+1, ... one per cycle. No requester is starved for more than N_REQ-1 cycles while unlocked.
- Requester contract: a requester holds REQ/ADDR/WDATA until it sees GNT. The arbiter does not buffer denied requests.
- Reset mid-operation: RST_N low in LOCKED aborts the lock, clears RF_WE immediately (asynchronously), and no partial write occurs.
- BUSY is the registered state==LOCKED.

Optional Feature:
- Macro: REGFILE_WR_ARB_STATS_EN.
- When defined, adds output STAT_GNT_CNT (N_REQ*16), packed per-requester saturating grant counters.
  - Counter i increments on every GNT[i] edge, including x0 writes.
  - Counters saturate at 16'hFFFF and are cleared by RST_N.
- When undefined, the port and counters are absent. All other behaviour is identical.

Decomposition:
- Shared package regfile_pkg holds:
  - constants RF_AW=5, RF_DW=32, RF_NREGS=32;
  - state enum {ARB_IDLE, ARB_LOCKED}.
- One sub-module is natural: the existing 5-to-32 one-hot decoder (Decoder_5to32), instantiated on the registered address path to form RF_WE. Its output is masked by the write-valid bit and the x0 check.
- The round-robin search stays inline.

Test Plan:
- Reset: hold RST_N=0 with REQ=2'b11 -> GNT=0, RF_WE=0, BUSY=0. Release -> first grant goes to requester 0 (rr_ptr=0).
- Round-robin: REQ=2'b11 held, ADDR0=3, ADDR1=7, WDATA0=32'hA, WDATA1=32'hB -> GNT alternates 01,10,01. RF_WE alternates 32'h8 (data A) and 32'h80 (data B), each one cycle after its grant.
- x0 drop: REQ0=1, ADDR0=0, WDATA0=32'hFFFF_FFFF -> GNT=01, next cycle RF_WE=0.
- Lock burst:
  - Stimulus: REQ=2'b11 with rr_ptr=1, LOCK1=1 for 4 cycles, ADDR1=1..4.
  - Required: GNT=10 for 4 cycles and BUSY=1, with RF_WE = 2,4,8,16 on the following cycles; requester 0 stalled.
  - Then LOCK1=0 -> IDLE, and requester 0 is granted next.
- Async reset in lock: assert RST_N=0 mid-burst between edges -> RF_WE=0 immediately and BUSY=0. After release, state=IDLE and rr_ptr=0.
- Stats (REGFILE_WR_ARB_STATS_EN defined): 70000 consecutive grants to requester 0 -> STAT_GNT_CNT[15:0] = 16'hFFFF and requester 1's count = 0.
